// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - memory-mapped timer, LED/7-seg, systick and UART transmitter responder
//
// Purpose : zero-wait-state peripheral block on the MEM-stage data port.
//           The 64-byte window at BASE_ADDR holds an overflow timer with an interrupt,
//           LED and 7-segment output registers, a free-running systick counter
//           and an 8N1 UART transmitter.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           i_address             - byte address; [31:6] selects the window, [5:2] the word
//           i_mem_write_data      - store data
//           i_mem_read/i_mem_write- load/store strobes
//           o_mem_read_data       - combinational load data (0 on a miss or when not reading)
//           o_irq                 - timer interrupt (TCON[1] & TCON[2])
//           o_leds, o_digits      - LED and 7-segment registers
//           o_uart_tx             - UART serial line, idles high

module mmio_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic [31:0] i_mem_write_data,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    output logic [31:0] o_mem_read_data,
    output logic        o_irq,
    output logic [7:0]  o_leds,
    output logic [11:0] o_digits,
    output logic        o_uart_tx
);

    localparam int                  BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [3:0] OFF_TH      = 4'd0;
    localparam logic [3:0] OFF_TL      = 4'd1;
    localparam logic [3:0] OFF_TCON    = 4'd2;
    localparam logic [3:0] OFF_LED     = 4'd3;
    localparam logic [3:0] OFF_DIGI    = 4'd4;
    localparam logic [3:0] OFF_SYSTICK = 4'd5;
    localparam logic [3:0] OFF_TXD     = 4'd6;
    localparam logic [3:0] OFF_UCON    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // Register state
    logic [31:0]       r_th;
    logic [31:0]       r_tl;
    logic [2:0]        r_tcon;
    logic [7:0]        r_leds;
    logic [11:0]       r_digits;
    logic [31:0]       r_systick;
    logic [7:0]        r_txd;
    logic              r_done;
    uart_state_t       r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic              r_uart_tx;

    // Decode
    logic        w_hit;
    logic [3:0]  w_off;
    logic        w_wr;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_wr_led;
    logic        w_wr_digi;
    logic        w_wr_txd;
    logic        w_wr_ucon;
    logic        w_overflow;
    logic        w_busy;
    logic        w_baud_last;
    logic [31:0] w_reg_rdata;
    logic        w_unused;

    assign w_hit     = (i_address[31:6] == BASE_ADDR[31:6]);
    assign w_off     = i_address[5:2];
    assign w_wr      = i_mem_write & w_hit;
    assign w_wr_th   = w_wr & (w_off == OFF_TH);
    assign w_wr_tl   = w_wr & (w_off == OFF_TL);
    assign w_wr_tcon = w_wr & (w_off == OFF_TCON);
    assign w_wr_led  = w_wr & (w_off == OFF_LED);
    assign w_wr_digi = w_wr & (w_off == OFF_DIGI);
    assign w_wr_txd  = w_wr & (w_off == OFF_TXD);
    assign w_wr_ucon = w_wr & (w_off == OFF_UCON);

    // Byte-lane bits of the address are deliberately ignored.
    assign w_unused = &{1'b0, i_address[1:0]};

    assign w_overflow  = r_tcon[0] & (r_tl == 32'hFFFF_FFFF);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    // Read mux reflects the pre-edge register values, so a simultaneous
    // load+store returns the old contents.
    always_comb begin
        w_reg_rdata = 32'd0;
        case (w_off)
            OFF_TH:      w_reg_rdata = r_th;
            OFF_TL:      w_reg_rdata = r_tl;
            OFF_TCON:    w_reg_rdata = {29'd0, r_tcon};
            OFF_LED:     w_reg_rdata = {24'd0, r_leds};
            OFF_DIGI:    w_reg_rdata = {20'd0, r_digits};
            OFF_SYSTICK: w_reg_rdata = r_systick;
            OFF_TXD:     w_reg_rdata = {24'd0, r_txd};
            OFF_UCON:    w_reg_rdata = {30'd0, r_done, w_busy};
            default:     w_reg_rdata = 32'd0;
        endcase
    end

    assign o_mem_read_data = (i_mem_read & w_hit) ? w_reg_rdata : 32'd0;
    assign o_irq           = r_tcon[1] & r_tcon[2];
    assign o_leds          = r_leds;
    assign o_digits        = r_digits;
    assign o_uart_tx       = r_uart_tx;

    // Timer, output registers and systick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_th      <= 32'd0;
            r_tl      <= 32'd0;
            r_tcon    <= 3'd0;
            r_leds    <= 8'd0;
            r_digits  <= 12'd0;
            r_systick <= 32'd0;
        end else begin
            r_systick <= r_systick + 32'd1;

            if (w_wr_th) begin
                r_th <= i_mem_write_data;
            end

            // A CPU store to TL overrides the count in the same cycle.
            if (w_wr_tl) begin
                r_tl <= i_mem_write_data;
            end else if (r_tcon[0]) begin
                r_tl <= w_overflow ? r_th : (r_tl + 32'd1);
            end

            if (w_wr_tcon) begin
                r_tcon <= i_mem_write_data[2:0];
            end
            // Placed after the CPU store so an overflow wins over a status clear.
            if (w_overflow && r_tcon[1]) begin
                r_tcon[2] <= 1'b1;
            end

            if (w_wr_led) begin
                r_leds <= i_mem_write_data[7:0];
            end
            if (w_wr_digi) begin
                r_digits <= i_mem_write_data[11:0];
            end
        end
    end

    // UART transmitter: the line is a registered output driven by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_uart_tx  <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_txd      <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            if (w_wr_ucon) begin
                r_done <= i_mem_write_data[1];
            end

            case (r_state)
                ST_IDLE: begin
                    r_uart_tx <= 1'b1;
                    if (w_wr_txd) begin
                        r_txd      <= i_mem_write_data[7:0];
                        r_state    <= ST_START;
                        r_uart_tx  <= 1'b0;
                        r_baud_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_uart_tx  <= r_txd[0];
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        // Index wraps 7 -> 0 on the last bit.
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_uart_tx <= 1'b1;
                            r_state   <= ST_STOP;
                        end else begin
                            r_uart_tx <= r_txd[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_state    <= ST_IDLE;
                        // Overrides a same-cycle CPU clear of done.
                        r_done     <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - scoreboard bench for mmio_responder with a behavioural model

module tb_mmio_responder;

    localparam int          CPB   = 16;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address;
    logic [31:0] i_mem_write_data;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [31:0] o_mem_read_data;
    logic        o_irq;
    logic [7:0]  o_leds;
    logic [11:0] o_digits;
    logic        o_uart_tx;

    mmio_responder #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_address       (i_address),
        .i_mem_write_data(i_mem_write_data),
        .i_mem_read      (i_mem_read),
        .i_mem_write     (i_mem_write),
        .o_mem_read_data (o_mem_read_data),
        .o_irq           (o_irq),
        .o_leds          (o_leds),
        .o_digits        (o_digits),
        .o_uart_tx       (o_uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  leds;
        logic [11:0] digits;
        logic        irq;
        logic        tx;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: register values plus a frame described by its start time.
    logic [31:0] m_th, m_tl, m_sys;
    logic [2:0]  m_tcon;
    logic [7:0]  m_leds, m_txd;
    logic [11:0] m_digi;
    bit          m_done, m_active;
    int          m_cyc = 0;
    int          m_start = 0;

    function automatic bit m_busy();
        return m_active && ((m_cyc - m_start) < FRAME);
    endfunction

    function automatic logic m_line();
        int t;
        if (!m_busy()) return 1'b1;
        t = m_cyc - m_start;
        if (t < CPB) return 1'b0;
        if (t < 9 * CPB) return m_txd[(t - CPB) / CPB];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if ((a >> 6) != (BASE >> 6)) return 32'd0;
        case (a[5:2])
            4'd0: return m_th;
            4'd1: return m_tl;
            4'd2: return {29'd0, m_tcon};
            4'd3: return {24'd0, m_leds};
            4'd4: return {20'd0, m_digi};
            4'd5: return m_sys;
            4'd6: return {24'd0, m_txd};
            4'd7: return {30'd0, m_done, m_busy()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit rst);
        bit          wv, ov, was_busy;
        logic [3:0]  off;
        logic [31:0] ntl;
        logic [2:0]  ntc;
        m_cyc++;
        if (rst) begin
            m_th = 0; m_tl = 0; m_sys = 0; m_tcon = 0; m_leds = 0; m_txd = 0;
            m_digi = 0; m_done = 0; m_active = 0;
            return;
        end
        wv  = wr && ((a >> 6) == (BASE >> 6));
        off = a[5:2];
        m_cyc--;
        was_busy = m_busy();
        m_cyc++;
        ov  = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        ntl = m_tl;
        if (wv && off == 4'd1) ntl = d;
        else if (m_tcon[0]) ntl = ov ? m_th : m_tl + 32'd1;
        ntc = (wv && off == 4'd2) ? d[2:0] : m_tcon;
        if (ov && m_tcon[1]) ntc[2] = 1'b1;
        if (wv && off == 4'd0) m_th = d;
        m_tl   = ntl;
        m_tcon = ntc;
        if (wv && off == 4'd3) m_leds = d[7:0];
        if (wv && off == 4'd4) m_digi = d[11:0];
        m_sys = m_sys + 32'd1;
        if (wv && off == 4'd7) m_done = d[1];
        if (m_active && (m_cyc - m_start) == FRAME) m_done = 1'b1;
        if (wv && off == 4'd6 && !was_busy) begin
            m_txd    = d[7:0];
            m_active = 1'b1;
            m_start  = m_cyc;
        end
    endtask

    // One bus cycle: drive after the edge, record the expectation, advance the model.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                         input bit rst, input bit chk, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        i_address        = a;
        i_mem_write_data = d;
        i_mem_read       = rd;
        i_mem_write      = wr;
        if (chk) begin
            e.rdata  = rd ? exp_read(a) : 32'd0;
            e.leds   = m_leds;
            e.digits = m_digi;
            e.irq    = m_tcon[1] & m_tcon[2];
            e.tx     = m_line();
            e.tag    = tag;
            q.push_back(e);
        end
        model_edge(a, d, wr, rst);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input string tag);
        cycle(a, d, 1'b0, 1'b1, 1'b0, 1'b1, tag);
    endtask

    task automatic rd_reg(input logic [31:0] a, input string tag);
        cycle(a, $urandom, 1'b1, 1'b0, 1'b0, 1'b1, tag);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".rdata"},  o_mem_read_data, e.rdata);
            chk({e.tag, ".leds"},   {24'd0, o_leds}, {24'd0, e.leds});
            chk({e.tag, ".digits"}, {20'd0, o_digits}, {20'd0, e.digits});
            chk({e.tag, ".irq"},    {31'd0, o_irq}, {31'd0, e.irq});
            chk({e.tag, ".tx"},     {31'd0, o_uart_tx}, {31'd0, e.tx});
        end
    end

    initial begin
        reset = 1'b1; i_address = 0; i_mem_write_data = 0; i_mem_read = 0; i_mem_write = 0;

        // Reset: two unchecked edges, then a checked cycle with reset still high.
        cycle(0, 0, 0, 0, 1, 0, "rst");
        cycle(0, 0, 0, 0, 1, 0, "rst");
        cycle(BASE + 32'h14, 0, 1, 0, 1, 1, "rst_hold");
        for (int i = 0; i < 8; i++) rd_reg(BASE + 32'(4 * i), "rst_regs");
        rd_reg(BASE + 32'h14, "systick");

        // LED / DIGI / misses / read-during-write
        wr_reg(BASE + 32'h0C, 32'hA5, "led_wr");
        rd_reg(BASE + 32'h0C, "led_rd");
        wr_reg(BASE + 32'h10, 32'hFFF, "digi_wr");
        rd_reg(BASE + 32'h10, "digi_rd");
        wr_reg(BASE + 32'h40, 32'hDEAD_BEEF, "miss_wr");
        rd_reg(BASE + 32'h40, "miss_rd");
        rd_reg(BASE + 32'h0C, "led_after_miss");
        cycle(BASE + 32'h0C, 32'h3C, 1, 1, 0, 1, "rw_same");
        rd_reg(BASE + 32'h0F, "led_bytelane");
        rd_reg(BASE + 32'h24, "unused_off");

        // Timer overflow and irq
        wr_reg(BASE + 32'h00, 32'hFFFF_FFFC, "th_wr");
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFE, "tl_wr");
        wr_reg(BASE + 32'h08, 32'h3, "tcon_on");
        for (int i = 0; i < 4; i++) rd_reg(BASE + 32'h04, "tl_count");
        rd_reg(BASE + 32'h08, "tcon_irq");
        wr_reg(BASE + 32'h08, 32'h3, "tcon_clr");
        rd_reg(BASE + 32'h08, "tcon_after_clr");
        wr_reg(BASE + 32'h08, 32'h0, "tcon_off");

        // Overflow coinciding with a status clear
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFF, "tl_max");
        wr_reg(BASE + 32'h08, 32'h3, "tcon_on2");
        cycle(BASE + 32'h08, 32'h3, 1, 1, 0, 1, "ovf_vs_clr");
        rd_reg(BASE + 32'h08, "set_wins");
        rd_reg(BASE + 32'h04, "tl_reload");
        // TL store coinciding with a count
        wr_reg(BASE + 32'h08, 32'h1, "tcon_en");
        wr_reg(BASE + 32'h04, 32'h0000_1234, "tl_vs_count");
        rd_reg(BASE + 32'h04, "tl_written");
        wr_reg(BASE + 32'h08, 32'h0, "tcon_off2");

        // UART frame with a write while busy
        wr_reg(BASE + 32'h18, 32'h5A, "txd_5a");
        for (int i = 0; i < 20; i++) rd_reg(BASE + 32'h1C, "frame");
        wr_reg(BASE + 32'h18, 32'hFF, "txd_busy");
        for (int i = 0; i < FRAME; i++) rd_reg(BASE + 32'h1C, "frame");
        rd_reg(BASE + 32'h18, "txd_rd");
        wr_reg(BASE + 32'h1C, 32'h0, "done_clr");
        rd_reg(BASE + 32'h1C, "done_rd");

        // Reset mid-frame
        wr_reg(BASE + 32'h18, 32'h33, "txd_33");
        for (int i = 0; i < 40; i++) rd_reg(BASE + 32'h1C, "frame2");
        cycle(BASE + 32'h1C, 0, 1, 0, 1, 1, "abort");
        rd_reg(BASE + 32'h1C, "abort_con");
        rd_reg(BASE + 32'h18, "abort_txd");

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] a, d;
            bit          r, w, rs;
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'h40 + 32'($urandom_range(0, 63));
                1:       a = BASE - 32'($urandom_range(1, 64));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            d  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            r  = $urandom_range(0, 1) == 1;
            w  = $urandom_range(0, 3) == 0;
            rs = $urandom_range(0, 399) == 0;
            cycle(a, d, r, w, rs, 1, "rand");
        end

        cycle(0, 0, 0, 0, 0, 0, "drain");
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped peripheral responder on the CPU's data-memory port, occupying the MEM-stage address window at `BASE_ADDR`. It answers loads and stores with zero wait states. It contains:
- an overflow timer with an interrupt;
- LED and 7-segment output registers;
- a free-running systick counter;
- a UART transmitter.

The MEM-stage data path selects this block's read data whenever the address falls inside the window.

## Interface
- `BASE_ADDR`, `32'h4000_0000`: window base; the window is 64 bytes.
- `CLKS_PER_BIT`, `16`: clock cycles per UART bit. Must be ≥ 2.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `i_address`  input  32  byte address from the MEM stage.
- `i_mem_write_data`  input  32  store data.
- `i_mem_read`  input  1  load strobe.
- `i_mem_write`  input  1  store strobe.
- `o_mem_read_data`  output  32  load data; combinational.
- `o_irq`  output  1  timer interrupt request.
- `o_leds`  output  8  LED register.
- `o_digits`  output  12  7-segment register: `[11:8]` anode select, `[7:0]` segments.
- `o_uart_tx`  output  1  UART serial line; idles high.

## Operation
- **Address decode**
  - Hit when `i_address[31:6] == BASE_ADDR[31:6]`.
  - Word offset is `i_address[5:2]`; `i_address[1:0]` is ignored.
  - A miss never writes and returns 0.
- **Register map (byte offset)**
  - 0x00 TH: timer reload, RW.
  - 0x04 TL: timer count, RW.
  - 0x08 TCON: RW, bits `[2:0]`. `[0]` enable, `[1]` irq enable, `[2]` irq status.
  - 0x0C LED: RW, `[7:0]`.
  - 0x10 DIGI: RW, `[11:0]`.
  - 0x14 SYSTICK: RO.
  - 0x18 UART_TXD: W starts a transmission; R returns the last loaded byte.
  - 0x1C UART_CON: `[0]` busy (RO); `[1]` done (sticky, RW; writing 0 clears it).
  - Unused offsets read 0 and ignore writes. Unused bits read 0.
- **Reads**
  - `o_mem_read_data` = selected register when `i_mem_read` is high and the address hits; otherwise 0.
  - Reads have no side effects.
- **Writes**
  - Take effect at the clock edge where `i_mem_write` is high.
  - If read and write are both high, the write is performed and the read returns the pre-write value.
- **Timer**, while TCON[0] = 1, each cycle:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and TCON[2] <= 1 if TCON[1] = 1.
  - Otherwise TL <= TL + 1.
  - A CPU write to TL in the same cycle takes priority over the count.
  - A CPU write to TCON clearing bit 2 in the same cycle as an overflow leaves bit 2 at 1 (set wins).
- **Interrupt**: `o_irq` = TCON[1] & TCON[2].
- **Systick**: increments every cycle and wraps from 32'hFFFF_FFFF to 0. Writes are ignored.
- **UART transmitter FSM**: states IDLE, START, DATA, STOP.
  - IDLE: line = 1. A write to TXD latches `data[7:0]`, sets busy, and goes to START.
  - START: line = 0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit bit index wraps 7 -> 0 and then exits to STOP.
  - STOP: line = 1 for `CLKS_PER_BIT` cycles, then IDLE. Busy clears and done is set.
  - A write to TXD while busy is ignored: both the latched byte and the transmission are unchanged.
  - Done set by the FSM takes priority over a CPU clear in the same cycle.
- **Reset**
  - All registers, TL, SYSTICK and the UART baud counter go to 0. FSM goes to IDLE.
  - Outputs: `o_irq` = 0, `o_leds` = 0, `o_digits` = 0, `o_uart_tx` = 1.
  - Reset during a transmission aborts it immediately. The line returns high on the next edge.

## Timing
- Load latency: 0 cycles (combinational), so the MEM/WB register captures the value in the same cycle.
- Store: visible to a load issued on the following cycle.
- TL/TH/TCON updates appear 1 cycle after the triggering edge. `o_irq` rises 1 cycle after the overflow edge.
- `o_uart_tx` falls on the first edge after the TXD write.
- A frame lasts 10 × `CLKS_PER_BIT` cycles: 160 at the default `CLKS_PER_BIT`.
- Busy reads 1 from the cycle after the write until the end of STOP.

## Test plan
- **Reset**: assert `reset` 2 cycles -> every output at its reset value; all registers read 0 except SYSTICK, which is counting after release. SYSTICK read 5 cycles after release = 5 (±1 per capture point, fixed by the bench).
- **LED/DIGI and misses**:
  - Write 0xA5 to 0x4000000C -> `o_leds` = 0xA5 next cycle.
  - Write 0xFFF to 0x40000010 -> `o_digits` = 0xFFF.
  - Write to 0x40000040 -> no change; read of that address = 0.
- **Timer**:
  - Load TH = 0xFFFF_FFFC and TL = 0xFFFF_FFFE, then write TCON = 3 -> TL reloads to 0xFFFF_FFFC after 2 counts and `o_irq` = 1.
  - Write TCON = 3 (clears bit 2) -> `o_irq` = 0.
- **Timer collisions**:
  - Overflow and a TCON bit-2 clear in the same cycle -> status stays 1.
  - TL write coinciding with a count -> the written value wins.
- **UART frame**: write 0x5A to TXD -> line low for 16 cycles, then data bits 0,1,0,1,1,0,1,0 at 16 cycles each, then high for 16 cycles. Busy = 1 throughout; done = 1 afterwards.
- **UART busy and abort**:
  - Write 0xFF to TXD mid-frame -> the frame still carries 0x5A.
  - Assert `reset` mid-frame -> `o_uart_tx` = 1 and busy = 0.
